aes_mixcol_seq: RTL and testbench

AES_MIXCOL_SEQ -- requirements
Module: aes_mixcol_seq

---
 rtl/aes_pkg.sv | 20 ++
 rtl/aes_mixw.sv | 29 ++
 rtl/aes_mixcol_seq.sv | 106 ++++++++++
 tb/tb_aes_mixcol_seq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the MixColumns datapath: field constants,
// column geometry, the sequencer state encoding and the GF(2^8) doubling.
package aes_pkg;

    localparam logic [7:0] AES_POLY  = 8'h1b;
    localparam int         AES_NCOL  = 4;
    localparam int         AES_COL_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mc_state_t;

    // Multiply by x in GF(2^8), reducing by the AES polynomial on overflow.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (AES_POLY & {8{x[7]}});
    endfunction

endpackage

// File: rtl/aes_mixw.sv
// Single-column forward MixColumns, purely combinational.
// Byte 0 of the column sits in [31:24], byte 3 in [7:0].
module aes_mixw
    import aes_pkg::*;
(
    input  logic [AES_COL_W-1:0] col_in,
    output logic [AES_COL_W-1:0] col_out
);

    logic [7:0] b0, b1, b2, b3;
    logic [7:0] x0, x1, x2, x3;

    assign b0 = col_in[31:24];
    assign b1 = col_in[23:16];
    assign b2 = col_in[15:8];
    assign b3 = col_in[7:0];

    assign x0 = xtime(b0);
    assign x1 = xtime(b1);
    assign x2 = xtime(b2);
    assign x3 = xtime(b3);

    // 3b is formed as xtime(b) ^ b.
    assign col_out[31:24] = x0 ^ (x1 ^ b1) ^ b2 ^ b3;
    assign col_out[23:16] = b0 ^ x1 ^ (x2 ^ b2) ^ b3;
    assign col_out[15:8]  = b0 ^ b1 ^ x2 ^ (x3 ^ b3);
    assign col_out[7:0]   = (x0 ^ b0) ^ b1 ^ b2 ^ x3;

endmodule

// File: rtl/aes_mixcol_seq.sv
// Sequential AES forward MixColumns. A 128-bit state is captured in IDLE,
// mixed COLS_PER_CYCLE columns at a time in CALC, and held in DONE until
// downstream takes it. A bypassed state skips CALC entirely.
module aes_mixcol_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_bits,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_bits,
    output logic         busy
);

    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] COL_LAST = 2'(AES_NCOL - COLS_PER_CYCLE);
    localparam logic [1:0] LAST_IDX = 2'(AES_NCOL - 1);

    mc_state_t state_q, state_d;
    logic [1:0] col_q, col_d;
    // Packed so that work_q[3] is column 0 ([127:96]) and work_q[0] is column 3.
    logic [AES_NCOL-1:0][AES_COL_W-1:0] work_q, work_d;
    logic bypass_q, bypass_d;

    logic [1:0]           col_sel [COLS_PER_CYCLE];
    logic [AES_COL_W-1:0] mix_in  [COLS_PER_CYCLE];
    logic [AES_COL_W-1:0] mix_out [COLS_PER_CYCLE];

    // One mixer per column handled in a CALC cycle, fed from the addressed columns.
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_mix
        assign col_sel[g] = col_q + 2'(g);
        assign mix_in[g]  = work_q[LAST_IDX - col_sel[g]];

        aes_mixw u_mixw (
            .col_in  (mix_in[g]),
            .col_out (mix_out[g])
        );
    end

    // Next-state, counter and working-register update for the three-state sequencer.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        col_d    = col_q;
        work_d   = work_q;
        bypass_d = bypass_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d   = in_bits;
                    bypass_d = in_bypass;
                    col_d    = '0;
                    state_d  = in_bypass ? DONE : CALC;
                end
            end
            CALC: begin
                if (!bypass_q) begin
                    for (int i = 0; i < COLS_PER_CYCLE; i++) begin
                        work_d[LAST_IDX - col_sel[i]] = mix_out[i];
                    end
                end
                if (col_q == COL_LAST) begin
                    col_d   = '0;
                    state_d = DONE;
                end else begin
                    col_d = col_q + COL_STEP;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset; reset discards any partial result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            col_q    <= '0;
            // NOTE: the working register is reset too, so out_bits is never X after reset.
            work_q   <= '0;
            bypass_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            state_q  <= state_d;
            col_q    <= col_d;
            work_q   <= work_d;
            bypass_q <= bypass_d;
        end
    end

    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_bits  = work_q;

endmodule

// File: tb/tb_aes_mixcol_seq.sv
// Directed bench for aes_mixcol_seq: three instances (1, 2 and 4 columns per
// cycle) share data inputs and have private handshakes.
module tb_aes_mixcol_seq;

    localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] D4_IN    = 128'h00000000_00000000_d4d4d4d5_00000000;
    localparam logic [127:0] D4_OUT   = 128'h00000000_00000000_d5d5d7d6_00000000;
    localparam logic [127:0] V3_IN    = 128'h2d26314c_01000000_80000000_00000000;
    localparam logic [127:0] V3_OUT   = 128'h4d7ebdf8_02010103_1b80809b_00000000;
    localparam logic [127:0] BYP_IN   = 128'h01234567_89abcdef_fedcba98_76543210;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] in_bits;
    logic         in_bypass;
    logic [2:0]   in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] out_bits [3];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    aes_mixcol_seq #(.COLS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_bits(in_bits), .in_bypass(in_bypass), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_bits(out_bits[0]), .busy(busy[0])
    );
    aes_mixcol_seq #(.COLS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_bits(in_bits), .in_bypass(in_bypass), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_bits(out_bits[1]), .busy(busy[1])
    );
    aes_mixcol_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_bits(in_bits), .in_bypass(in_bypass), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_bits(out_bits[2]), .busy(busy[2])
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Generic GF(2^8) multiply, used only for the inverse transform.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   b0, b1, b2, b3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            {b0, b1, b2, b3} = s[127 - 32*c -: 32];
            r[127 - 32*c -: 32] = {
                gmul(b0, 8'h0e) ^ gmul(b1, 8'h0b) ^ gmul(b2, 8'h0d) ^ gmul(b3, 8'h09),
                gmul(b0, 8'h09) ^ gmul(b1, 8'h0e) ^ gmul(b2, 8'h0b) ^ gmul(b3, 8'h0d),
                gmul(b0, 8'h0d) ^ gmul(b1, 8'h09) ^ gmul(b2, 8'h0e) ^ gmul(b3, 8'h0b),
                gmul(b0, 8'h0b) ^ gmul(b1, 8'h0d) ^ gmul(b2, 8'h09) ^ gmul(b3, 8'h0e)};
        end
        return r;
    endfunction

    // One full transaction on instance sel. lat counts edges from accept to the
    // first edge that samples out_valid high; 40 means it never came.
    task automatic xfer(input int sel, input logic [127:0] data, input logic byp,
                        input logic early_ready, output logic [127:0] res, output int lat);
        check($sformatf("ready_before_accept[%0d]", sel), in_ready[sel], 1'b1);
        in_bits         = data;
        in_bypass       = byp;
        in_valid[sel]   = 1'b1;
        out_ready[sel]  = early_ready;
        tick();
        in_valid[sel] = 1'b0;
        in_bits       = ~data;
        in_bypass     = 1'b0;
        lat           = 1;
        while (!out_valid[sel] && lat < 40) begin
            tick();
            lat++;
        end
        res            = out_bits[sel];
        out_ready[sel] = 1'b1;
        tick();
        out_ready[sel] = 1'b0;
        check($sformatf("idle_after_handshake[%0d]", sel), {in_ready[sel], out_valid[sel]}, 2'b10);
    endtask

    initial begin
        logic [127:0] res;
        logic [127:0] data;
        int           lat;
        logic         seen;

        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = '0;
        in_bits   = '0;
        in_bypass = 1'b0;
        repeat (3) tick();

        check("rst_in_ready", in_ready, 3'b000);
        check("rst_busy", busy, 3'b000);
        check("rst_out_valid", out_valid, 3'b000);
        for (int s = 0; s < 3; s++) check($sformatf("rst_out_bits[%0d]", s), out_bits[s], '0);
        rst_n = 1'b1;
        #1;
        check("in_ready_after_rst", in_ready, 3'b111);
        tick();

        // FIPS-197 vector at 1 and 2 columns per cycle.
        xfer(0, FIPS_IN, 1'b0, 1'b0, res, lat);
        check("fips_c1_bits", res, FIPS_OUT);
        check("fips_c1_lat", lat, 5);
        xfer(1, FIPS_IN, 1'b0, 1'b0, res, lat);
        check("fips_c2_bits", res, FIPS_OUT);
        check("fips_c2_lat", lat, 3);

        // Single non-zero column at 4 columns per cycle.
        xfer(2, D4_IN, 1'b0, 1'b0, res, lat);
        check("d4_c4_bits", res, D4_OUT);
        check("d4_c4_lat", lat, 2);

        // Reduction boundary bytes; out_ready held high from before accept.
        xfer(0, V3_IN, 1'b0, 1'b1, res, lat);
        check("v3_early_ready_bits", res, V3_OUT);
        check("v3_early_ready_lat", lat, 5);
        xfer(2, V3_IN, 1'b0, 1'b0, res, lat);
        check("v3_c4_bits", res, V3_OUT);

        // Bypass passes the state unmixed after one edge on every instance.
        for (int s = 0; s < 3; s++) begin
            xfer(s, BYP_IN, 1'b1, 1'b0, res, lat);
            check($sformatf("bypass_bits[%0d]", s), res, BYP_IN);
            check($sformatf("bypass_lat[%0d]", s), lat, 1);
        end

        // Hold the result in DONE while new input is offered.
        in_bits     = FIPS_IN;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        lat = 1;
        while (!out_valid[0] && lat < 40) begin
            tick();
            lat++;
        end
        check("stall_lat", lat, 5);
        for (int i = 0; i < 10; i++) begin
            in_valid[0] = ~in_valid[0];
            in_bits     = {$urandom, $urandom, $urandom, $urandom};
            tick();
            check("stall_bits", out_bits[0], FIPS_OUT);
            check("stall_ready_valid", {in_ready[0], out_valid[0]}, 2'b01);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
        check("stall_release", {in_ready[0], busy[0]}, 2'b10);

        // Reset during CALC with the counter at column 2 aborts the state.
        in_bits     = FIPS_IN;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        tick();
        tick();
        check("abort_busy_before", busy[0], 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready_in_rst", in_ready, 3'b000);
        tick();
        rst_n = 1'b1;
        #1;
        check("abort_idle_after", {in_ready[0], busy[0]}, 2'b10);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid[0]) seen = 1'b1;
        end
        check("abort_no_valid", seen, 1'b0);
        xfer(0, FIPS_IN, 1'b0, 1'b0, res, lat);
        check("abort_next_bits", res, FIPS_OUT);
        check("abort_next_lat", lat, 5);

        // Round trip through an independent inverse MixColumns.
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 20; i++) begin
                data = {$urandom, $urandom, $urandom, $urandom};
                xfer(s, data, 1'b0, 1'b0, res, lat);
                check($sformatf("roundtrip[%0d]", s), inv_mix(res), data);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
